// File: rtl/id_stage_hazard.sv
// Instruction-decode stage with an integrated register file, write-back bypass,
// load-use interlock and downstream stall/flush handling of the ID/EX register.
module id_stage_hazard #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NREGS      = 16,
    parameter bit          IMM_SIGNED = 1'b1,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       inst,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [3:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic              out_valid,
    output logic [1:0]        out_type,
    output logic [3:0]        out_op,
    output logic [3:0]        out_rd,
    output logic [3:0]        out_ra,
    output logic [3:0]        out_rb,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_wr_en
);

    typedef struct packed {
        logic              valid;
        logic [1:0]        typ;
        logic [3:0]        op;
        logic [3:0]        rd;
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic              wr_en;
    } dec_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    dec_t              dec_d, dec_q;
    logic [DATA_W-1:0] rd1_val, rd2_val;
    logic [63:0]       imm18_ext, imm26_ext;
    logic [3:0]        ra, rb;
    logic              ra_used, rb_used, hazard;

    assign ra = inst[21:18];
    assign rb = inst[17:14];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_q <= '{default: '0};
        end else if (wb_we && 32'(wb_rd) < NREGS) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Out-of-range fields read as zero; bypass only matters for implemented registers.
    always_comb begin
        rd1_val = '0;
        if (32'(ra) < NREGS) begin
            if (BYPASS_EN && wb_we && wb_rd == ra) rd1_val = wb_data;
            else                                   rd1_val = rf_q[ra];
        end
    end

    always_comb begin
        rd2_val = '0;
        if (32'(rb) < NREGS) begin
            if (BYPASS_EN && wb_we && wb_rd == rb) rd2_val = wb_data;
            else                                   rd2_val = rf_q[rb];
        end
    end

    assign imm18_ext = IMM_SIGNED ? {{46{inst[17]}}, inst[17:0]} : {46'b0, inst[17:0]};
    assign imm26_ext = {{38{inst[25]}}, inst[25:0]};

    always_comb begin
        dec_d = '0;
        if (in_valid) begin
            dec_d.valid = 1'b1;
            dec_d.typ   = inst[31:30];
            dec_d.op    = inst[29:26];
            dec_d.rd    = inst[25:22];
            dec_d.ra    = ra;
            dec_d.rb    = rb;
            dec_d.rd1   = rd1_val;
            dec_d.rd2   = rd2_val;
            case (inst[31:30])
                2'b01, 2'b10: dec_d.imm = imm18_ext[DATA_W-1:0];
                2'b11:        dec_d.imm = imm26_ext[DATA_W-1:0];
                default:      dec_d.imm = '0;
            endcase
            dec_d.wr_en = (inst[31:30] == 2'b00) || (inst[31:30] == 2'b01) ||
                          (inst[31:30] == 2'b10 && inst[29:26] == 4'b0000);
        end
    end

    assign ra_used = (inst[31:30] != 2'b11);
    assign rb_used = (inst[31:30] == 2'b00) ||
                     (inst[31:30] == 2'b10 && inst[29:26] == 4'b0001);

    // A load in ID/EX whose destination feeds the incoming instruction forces one bubble.
    assign hazard = in_valid && dec_q.valid && dec_q.typ == 2'b10 && dec_q.op == 4'b0000 &&
                    ((ra_used && ra == dec_q.rd) || (rb_used && rb == dec_q.rd));

    assign stall_out = rst && !flush && (stall_in || hazard);

    always_ff @(posedge clk) begin
        if (!rst) begin
            dec_q <= '0;
        end else if (flush) begin
            dec_q <= '0;
        end else if (stall_in) begin
            dec_q <= dec_q;
        end else if (hazard) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign out_valid = dec_q.valid;
    assign out_type  = dec_q.typ;
    assign out_op    = dec_q.op;
    assign out_rd    = dec_q.rd;
    assign out_ra    = dec_q.ra;
    assign out_rb    = dec_q.rb;
    assign out_rd1   = dec_q.rd1;
    assign out_rd2   = dec_q.rd2;
    assign out_imm   = dec_q.imm;
    assign out_wr_en = dec_q.wr_en;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: vector table plus hand-built hazard/stall/flush sequences,
// with expected ID/EX contents queued when driven and compared one cycle later.
module tb_id_stage_hazard;

    typedef struct packed {
        logic        valid;
        logic [1:0]  typ;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        wr_en;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic        in_valid;
        logic        stall;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall_in, flush, wb_we;
    logic [31:0] inst, wb_data;
    logic [3:0]  wb_rd;

    logic        stall_out, out_valid, out_wr_en;
    logic [1:0]  out_type;
    logic [3:0]  out_op, out_rd, out_ra, out_rb;
    logic [31:0] out_rd1, out_rd2, out_imm;

    logic        nb_stall_out, nb_out_valid, nb_out_wr_en;
    logic [1:0]  nb_out_type;
    logic [3:0]  nb_out_op, nb_out_rd, nb_out_ra, nb_out_rb;
    logic [31:0] nb_out_rd1, nb_out_rd2, nb_out_imm;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    vec_t vecs[7];
    exp_t bubble;

    always #5 clk = ~clk;

    id_stage_hazard dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .stall_in(stall_in),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_out(stall_out), .out_valid(out_valid), .out_type(out_type), .out_op(out_op),
        .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb), .out_rd1(out_rd1),
        .out_rd2(out_rd2), .out_imm(out_imm), .out_wr_en(out_wr_en)
    );

    id_stage_hazard #(.BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .stall_in(stall_in),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_out(nb_stall_out), .out_valid(nb_out_valid), .out_type(nb_out_type),
        .out_op(nb_out_op), .out_rd(nb_out_rd), .out_ra(nb_out_ra), .out_rb(nb_out_rb),
        .out_rd1(nb_out_rd1), .out_rd2(nb_out_rd2), .out_imm(nb_out_imm),
        .out_wr_en(nb_out_wr_en)
    );

    function automatic exp_t mk(input logic v, input logic [1:0] t, input logic [3:0] op,
                                input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic we);
        exp_t e;
        e.valid = v; e.typ = t; e.op = op; e.rd = rd; e.ra = ra; e.rb = rb;
        e.rd1 = d1; e.rd2 = d2; e.imm = imm; e.wr_en = we;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({name, ".queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({name, ".valid"}, {31'b0, out_valid}, {31'b0, e.valid});
        check({name, ".type"},  {30'b0, out_type},  {30'b0, e.typ});
        check({name, ".op"},    {28'b0, out_op},    {28'b0, e.op});
        check({name, ".rd"},    {28'b0, out_rd},    {28'b0, e.rd});
        check({name, ".ra"},    {28'b0, out_ra},    {28'b0, e.ra});
        check({name, ".rb"},    {28'b0, out_rb},    {28'b0, e.rb});
        check({name, ".rd1"},   out_rd1,            e.rd1);
        check({name, ".rd2"},   out_rd2,            e.rd2);
        check({name, ".imm"},   out_imm,            e.imm);
        check({name, ".wr_en"}, {31'b0, out_wr_en}, {31'b0, e.wr_en});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name);
        tick();
        check_out(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bubble = '0;
        // Registers after preload: r2=7, r10=3, all others 0.
        vecs[0] = '{32'h204A8000, 1'b1, 1'b0, mk(1, 2'd0, 4'd8, 4'd1, 4'd2, 4'd10, 7, 3, 0, 1)};
        vecs[1] = '{32'h5698000F, 1'b1, 1'b0, mk(1, 2'd1, 4'd5, 4'd10, 4'd6, 4'd0, 0, 0, 15, 1)};
        vecs[2] = '{32'h569A000F, 1'b1, 1'b0,
                    mk(1, 2'd1, 4'd5, 4'd10, 4'd6, 4'd8, 0, 0, 32'hFFFE000F, 1)};
        vecs[3] = '{32'h84CA8005, 1'b1, 1'b0,
                    mk(1, 2'd2, 4'd1, 4'd3, 4'd2, 4'd10, 7, 3, 32'hFFFE8005, 0)};
        vecs[4] = '{32'h83C00000, 1'b1, 1'b0, mk(1, 2'd2, 4'd0, 4'd15, 4'd0, 4'd0, 0, 0, 0, 1)};
        // Branch naming r15 right after ld r15 must not interlock.
        vecs[5] = '{32'hCE3C0001, 1'b1, 1'b0,
                    mk(1, 2'd3, 4'd3, 4'd8, 4'd15, 4'd0, 0, 0, 32'hFE3C0001, 0)};
        vecs[6] = '{32'h204A8000, 1'b0, 1'b0, '0};

        rst = 1'b0; in_valid = 1'b0; inst = '0; stall_in = 1'b1; flush = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        tick();
        check("reset_stall_out", {31'b0, stall_out}, 32'd0);
        tick();
        exp_q.push_back(bubble);
        check_out("reset");
        rst = 1'b1; stall_in = 1'b0;

        inst = 32'h00140000; in_valid = 1'b1;
        exp_q.push_back(mk(1, 2'd0, 4'd0, 4'd0, 4'd5, 4'd0, 0, 0, 0, 1));
        step("read_r5");

        in_valid = 1'b0; wb_we = 1'b1; wb_rd = 4'd2; wb_data = 32'd7;
        exp_q.push_back(bubble);
        step("preload_r2");
        wb_rd = 4'd10; wb_data = 32'd3;
        exp_q.push_back(bubble);
        step("preload_r10");
        wb_we = 1'b0;

        for (int i = 0; i < 7; i++) begin
            inst = vecs[i].inst; in_valid = vecs[i].in_valid;
            #1;
            check($sformatf("vec%0d.stall_out", i), {31'b0, stall_out}, {31'b0, vecs[i].stall});
            exp_q.push_back(vecs[i].exp);
            step($sformatf("vec%0d", i));
        end

        // Same-cycle write-back forwarding versus the non-bypassing instance.
        inst = 32'h00080000; in_valid = 1'b1; wb_we = 1'b1; wb_rd = 4'd2; wb_data = 32'hDEAD;
        exp_q.push_back(mk(1, 2'd0, 4'd0, 4'd0, 4'd2, 4'd0, 32'hDEAD, 0, 0, 1));
        step("bypass");
        check("nobypass.rd1", nb_out_rd1, 32'd7);
        wb_we = 1'b0;

        // Load-use on Ra: one stall cycle, one bubble, then the add issues.
        inst = 32'h83C00000;
        exp_q.push_back(mk(1, 2'd2, 4'd0, 4'd15, 4'd0, 4'd0, 0, 0, 0, 1));
        step("lu_ld");
        inst = 32'h007C8000;
        #1;
        check("lu_stall_on", {31'b0, stall_out}, 32'd1);
        exp_q.push_back(bubble);
        step("lu_bubble");
        check("lu_stall_off", {31'b0, stall_out}, 32'd0);
        exp_q.push_back(mk(1, 2'd0, 4'd0, 4'd1, 4'd15, 4'd2, 0, 32'hDEAD, 0, 1));
        step("lu_add");

        inst = 32'h83C00000;
        exp_q.push_back(mk(1, 2'd2, 4'd0, 4'd15, 4'd0, 4'd0, 0, 0, 0, 1));
        step("nd_ld");
        inst = 32'h00448000;
        #1;
        check("nd_stall", {31'b0, stall_out}, 32'd0);
        exp_q.push_back(mk(1, 2'd0, 4'd0, 4'd1, 4'd1, 4'd2, 0, 32'hDEAD, 0, 1));
        step("nd_add");

        // Store reading r15 through Rb interlocks; flush with stall_in overrides it.
        inst = 32'h83C00000;
        exp_q.push_back(mk(1, 2'd2, 4'd0, 4'd15, 4'd0, 4'd0, 0, 0, 0, 1));
        step("fl_ld");
        inst = 32'h8403C000;
        #1;
        check("st_rb_hazard", {31'b0, stall_out}, 32'd1);
        flush = 1'b1; stall_in = 1'b1;
        #1;
        check("flush_stall_out", {31'b0, stall_out}, 32'd0);
        exp_q.push_back(bubble);
        step("flush");
        flush = 1'b0; stall_in = 1'b0;

        // Downstream stall holds output; register writes still land meanwhile.
        inst = 32'h204A8000;
        exp_q.push_back(mk(1, 2'd0, 4'd8, 4'd1, 4'd2, 4'd10, 32'hDEAD, 3, 0, 1));
        step("pre_hold");
        inst = 32'h5698000F; stall_in = 1'b1; wb_we = 1'b1; wb_rd = 4'd6; wb_data = 32'h55;
        #1;
        check("hold_stall_out", {31'b0, stall_out}, 32'd1);
        exp_q.push_back(mk(1, 2'd0, 4'd8, 4'd1, 4'd2, 4'd10, 32'hDEAD, 3, 0, 1));
        step("hold");
        stall_in = 1'b0; wb_we = 1'b0;
        exp_q.push_back(mk(1, 2'd1, 4'd5, 4'd10, 4'd6, 4'd0, 32'h55, 0, 15, 1));
        step("after_hold");

        // Reset during a stall drops the held instruction and clears the register file.
        inst = 32'h204A8000; stall_in = 1'b1; rst = 1'b0;
        #1;
        check("rst_stall_out", {31'b0, stall_out}, 32'd0);
        exp_q.push_back(bubble);
        step("mid_reset");
        rst = 1'b1; stall_in = 1'b0;
        exp_q.push_back(mk(1, 2'd0, 4'd8, 4'd1, 4'd2, 4'd10, 0, 0, 0, 1));
        step("post_reset_regs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
